// File: rtl/map_trellis_pkg.sv
// Shared trellis description for the max-log MAP decoder.
// 8-state RSC code, feedback 13 (octal), feedforward 15 (octal).
// State index s = {d1,d2,d3} (d1 = most recent register bit).
// Input u with state s gives a = u^d2^d3, parity p = a^d1^d3, next state {a,d1,d2}.
// For each next state s': PRED0/PRED1 are its two predecessors (lower index first)
// and LBL0/LBL1 are the matching 2-bit gamma indices {u,p}.
package map_trellis_pkg;

  localparam int NUM_STATES = 8;

  typedef logic [2:0] state_idx_t;
  typedef logic [1:0] lbl_t;

  localparam state_idx_t PRED0 [NUM_STATES] =
    '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6};
  localparam state_idx_t PRED1 [NUM_STATES] =
    '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7};
  localparam lbl_t LBL0 [NUM_STATES] =
    '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0};
  localparam lbl_t LBL1 [NUM_STATES] =
    '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } fsm_state_t;

  // Metric for unreachable states: a quarter of the range, so adding a
  // gamma can never overflow the W+2-bit sums.
  function automatic longint neg_inf(int w);
    return -(longint'(1) <<< (w - 2));
  endfunction

endpackage

// File: rtl/alpha_fwd_engine_if.sv
// Data-path bundle of the alpha engine.
//   gamma_valid/gamma_ready/gamma : branch-metric stream {g11,g10,g01,g00}, g00 in LSBs
//   alpha_we/alpha_addr/alpha_data: alpha memory write port {a7..a0}, a0 in LSBs
// master: gamma producer / memory side.  slave: the engine.
interface alpha_fwd_engine_if #(
  parameter int W      = 16,
  parameter int ADDR_W = 8
);
  logic              gamma_valid;
  logic              gamma_ready;
  logic [4*W-1:0]    gamma;
  logic              alpha_we;
  logic [ADDR_W-1:0] alpha_addr;
  logic [8*W-1:0]    alpha_data;

  modport master (
    output gamma_valid, gamma,
    input  gamma_ready, alpha_we, alpha_addr, alpha_data
  );

  modport slave (
    input  gamma_valid, gamma,
    output gamma_ready, alpha_we, alpha_addr, alpha_data
  );
endinterface

// File: rtl/alpha_fwd_engine_acs.sv
// Add-compare-select for one trellis state.
//   alpha0/gamma0 : metric and branch metric along the first predecessor
//   alpha1/gamma1 : same for the second predecessor
//   max_o         : larger path sum, W+2 bits so the add never overflows
module acs_unit #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] alpha0,
  input  logic signed [W-1:0] alpha1,
  input  logic signed [W-1:0] gamma0,
  input  logic signed [W-1:0] gamma1,
  output logic signed [W+1:0] max_o
);
  logic signed [W+1:0] sum0;
  logic signed [W+1:0] sum1;

  always_comb begin
    sum0  = (W+2)'(alpha0) + (W+2)'(gamma0);
    sum1  = (W+2)'(alpha1) + (W+2)'(gamma1);
    // Strict compare: a tie keeps the first-predecessor candidate.
    max_o = (sum1 > sum0) ? sum1 : sum0;
  end
endmodule

// File: rtl/alpha_fwd_engine.sv
// Forward (alpha) recursion engine of the max-log MAP decoder.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begins a block (sampled only in IDLE)
//   blk_len         : trellis steps in the block, latched on start
//   init_mode       : 0 = known start state 0, 1 = unknown start; latched on start
//   bus             : gamma stream in, alpha memory write port out
//   busy            : block in progress (INIT and RUN)
//   done            : one-cycle pulse after the last alpha write
// Writes the initial vector at address 0, then one normalised vector per
// accepted gamma at addresses 1..blk_len.
module alpha_fwd_engine
  import map_trellis_pkg::*;
#(
  parameter int W      = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] blk_len,
  input  logic              init_mode,
  alpha_fwd_engine_if.slave bus,
  output logic              busy,
  output logic              done
);

  typedef logic [NUM_STATES-1:0][W-1:0] alpha_vec_t;

  localparam logic [W-1:0]        NEG_INF = W'(neg_inf(W));
  localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  fsm_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   k_q, k_d, k_inc;
  logic                mode_q, mode_d;
  alpha_vec_t          alpha_q, alpha_d;
  alpha_vec_t          init_vec, norm_vec;
  logic [3:0][W-1:0]   gamma_v;
  logic signed [W+1:0] acs_max   [NUM_STATES];
  logic signed [W+1:0] norm_diff [NUM_STATES];

  assign gamma_v = bus.gamma;
  // k never exceeds blk_len-1 in RUN, so k+1 fits even for the all-ones length.
  assign k_inc   = k_q + ADDR_W'(1);

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    acs_unit #(.W(W)) u_acs (
      .alpha0 (alpha_q[PRED0[s]]),
      .alpha1 (alpha_q[PRED1[s]]),
      .gamma0 (gamma_v[LBL0[s]]),
      .gamma1 (gamma_v[LBL1[s]]),
      .max_o  (acs_max[s])
    );
  end

  // Initial vector, and normalisation against state 0 followed by saturation.
  // The difference of two W+2-bit ACS results cannot overflow W+2 bits.
  always_comb begin
    init_vec  = '0;
    norm_vec  = '0;
    norm_diff = '{default: '0};
    for (int s = 1; s < NUM_STATES; s++) begin
      if (!mode_q) init_vec[s] = NEG_INF;
    end
    for (int s = 0; s < NUM_STATES; s++) begin
      norm_diff[s] = acs_max[s] - acs_max[0];
      if (norm_diff[s] > SAT_MAX)      norm_vec[s] = SAT_MAX[W-1:0];
      else if (norm_diff[s] < SAT_MIN) norm_vec[s] = SAT_MIN[W-1:0];
      else                             norm_vec[s] = norm_diff[s][W-1:0];
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    mode_d          = mode_q;
    k_d             = k_q;
    alpha_d         = alpha_q;
    bus.gamma_ready = 1'b0;
    bus.alpha_we    = 1'b0;
    bus.alpha_addr  = '0;
    bus.alpha_data  = '0;
    busy            = 1'b0;
    done            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          len_d   = blk_len;
          mode_d  = init_mode;
          k_d     = '0;
        end
      end
      ST_INIT: begin
        busy           = 1'b1;
        alpha_d        = init_vec;
        bus.alpha_we   = 1'b1;
        bus.alpha_data = init_vec;
        state_d        = (len_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy            = 1'b1;
        bus.gamma_ready = 1'b1;
        if (bus.gamma_valid) begin
          alpha_d        = norm_vec;
          bus.alpha_we   = 1'b1;
          bus.alpha_addr = k_inc;
          bus.alpha_data = norm_vec;
          k_d            = k_inc;
          if (k_inc == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the values present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
      alpha_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      alpha_q <= alpha_d;
    end
  end

endmodule

// File: doc/alpha_fwd_engine.md
Name: alpha_fwd_engine

Overview:
- Parametrised forward-recursion (alpha) engine for the max-log MAP decoder.
- Consumes one set of branch metrics per trellis step through a valid/ready stream.
- Computes the 8 alpha metrics with add-compare-select, then normalises and saturates them.
- Writes every alpha vector, initial one included, to the alpha memory.
- Sits between the gamma unit and the alpha RAM; the backward/LLR stage reads that RAM after done.

Parameters:
- W, 16, signed width of each alpha and gamma metric (W >= 8).
- ADDR_W, 8, alpha memory address width; the maximum block length is 2^ADDR_W - 1 steps.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a block; sampled only in IDLE.
- blk_len  in  ADDR_W  number of trellis steps; latched on start.
- init_mode  in  1  latched on start. 0 = known start: alpha0 = 0, all other states = NEG_INF. 1 = unknown start: all alphas 0.
- gamma_valid  in  1  gamma bus holds the metrics for the next step.
- gamma_ready  out  1  engine accepts gamma this cycle.
- gamma  in  4*W  signed branch metrics {g11,g10,g01,g00}; index = {u,p}, g00 in the LSBs.
- alpha_we  out  1  alpha memory write strobe.
- alpha_addr  out  ADDR_W  write address; equals the trellis step index.
- alpha_data  out  8*W  alpha vector {a7..a0}, a0 in the LSBs.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the alpha register is cleared.
- FSM states and transitions:
  - IDLE -> INIT on start. blk_len and init_mode are latched; the step counter k is set to 0.
  - INIT (1 cycle): loads the initial vector per init_mode into the alpha register and drives alpha_we=1, alpha_addr=0, alpha_data=initial vector. Next state is RUN, or DONE if blk_len==0.
  - RUN: gamma_ready=1. On each cycle with gamma_valid&gamma_ready:
    - compute the next vector combinationally from the alpha register and gamma;
    - register it and write it the same cycle: alpha_we=1, alpha_addr=k+1, alpha_data=new vector;
    - increment k.
    - When k+1==blk_len_latched, go to DONE.
    - With gamma_valid=0 the engine stalls: alpha_we=0 and all state is held.
  - DONE (1 cycle): done=1, busy=0 from this cycle on, then IDLE.
- Throughput and latency:
  - One step per cycle.
  - Total cycles from start to done = blk_len + 2.
  - Exactly blk_len+1 writes, at addresses 0..blk_len.
- ACS for each state s': alpha_new[s'] = max(alpha[p0]+g[u0,par0], alpha[p1]+g[u1,par1]).
  - Predecessors p0, p1 and their branch labels come from the package tables.
  - On a tie, the p0 candidate wins; the value is the same either way.
- Arithmetic:
  - Sums are formed in W+2 bits.
  - Normalisation: alpha_norm[s] = alpha_new[s] - alpha_new[0], applied every step.
  - Each result saturates to [-2^(W-1), 2^(W-1)-1] before it is registered.
  - Consequence: a0 is always 0 after step 0.
- NEG_INF = -2^(W-2), so unreachable states stay finite and do not overflow.
- Boundary and corner cases:
  - start while busy is ignored.
  - gamma_valid outside RUN is ignored, and gamma_ready is 0 there.
  - blk_len latched once; later input changes have no effect.
  - Reset mid-block aborts immediately. No done pulse is issued, and the next start begins cleanly.
  - blk_len = 2^ADDR_W-1 is legal; the last address is all-ones and there is no wrap.

Decomposition:
- Shared package map_trellis_pkg holds:
  - NUM_STATES=8 and the 8-state RSC trellis: feedback 13 octal, feedforward 15 octal;
  - constant tables PRED0/PRED1[8] (predecessor state) and LBL0/LBL1[8] (2-bit {u,p} gamma index);
  - NEG_INF as a function of W;
  - the FSM state enum.
- One sub-module, acs_unit. It takes two alphas and two gammas and outputs the W+2-bit max. It is instantiated 8 times via generate.
- Normalisation and saturation stay in the top module.

Test Plan:
- Unknown-start baseline: init_mode=1, blk_len=4, all gammas 0, gamma_valid held high -> 5 writes at addr 0..4, every alpha 0, done 6 cycles after start, busy low in the done cycle.
- Known-start reachability: init_mode=0, W=16, blk_len=3, gammas 0. Required writes:
  - addr0: a0=0, a1..a7=-16384;
  - addr1: exactly 2 states 0, rest -16384;
  - addr2: 4 states 0;
  - addr3: all 0.
- Stall handling: blk_len=4 with gamma_valid low 3 cycles between steps 2 and 3 -> no writes while stalled, alpha register held, results identical to the unstalled run, done 9 cycles after start.
- Saturation: W=8, init_mode=1, blk_len=2; g11=g10=127, g01=g00=-128 -> every output alpha lies within [-128,127], a0=0, no wrap in sign.
- blk_len=0 -> single write at addr 0, done 2 cycles after start. A start pulsed during RUN is ignored.
- Reset mid-block: rst low during step 2 -> all outputs 0 while low, no done pulse. A fresh start then completes normally with addresses starting at 0.
